axis_packetizer: RTL and testbench

Single-clock AXI-Stream stage that groups an unframed beat stream into packets by driving `tlast`. It is placed directly upstream of the async FIFO wrapper's sink, so that frames are formed before the clock-domain crossing. `tlast` is asserted on the `MAX_LEN`-th beat of a packet, on any beat that arrived with `tlast` set, on an idle timeout, or on an explicit flush. A one-beat hold register delays every beat until its `tlast` value is known.

---
 rtl/axis_packetizer_pkg.sv | 28 ++
 rtl/axis_interface.sv | 22 ++
 rtl/axis_idle_timer.sv | 34 +++
 rtl/axis_packetizer.sv | 142 ++++++++++++++
 tb/tb_axis_packetizer.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_packetizer_pkg.sv
// Shared types and constants for the AXI-Stream packetizer.
//   packetizer_state_t : occupancy of the hold register (EMPTY/PENDING/CLOSING)
//   hold_beat_t        : one buffered beat (payload, sideband, framing bit)
//   AXIS_*_WIDTH       : stream field widths used by the interface and the hold struct
//   PKT_COUNT_WIDTH    : width of the emitted-packet counter
package axis_packetizer_pkg;

  localparam int unsigned AXIS_DATA_WIDTH = 8;
  localparam int unsigned AXIS_ID_WIDTH   = 4;
  localparam int unsigned AXIS_DEST_WIDTH = 4;
  localparam int unsigned AXIS_USER_WIDTH = 1;
  localparam int unsigned PKT_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PENDING = 2'd1,
    CLOSING = 2'd2
  } packetizer_state_t;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] data;
    logic [AXIS_ID_WIDTH-1:0]   id;
    logic [AXIS_DEST_WIDTH-1:0] dest;
    logic [AXIS_USER_WIDTH-1:0] user;
    logic                       last;
  } hold_beat_t;

endpackage

// File: rtl/axis_interface.sv
// AXI-Stream bundle with Sink (consumer side) and Source (producer side) modports.
//   tdata/tkeep/tvalid/tlast/tid/tdest/tuser : producer -> consumer
//   tready                                    : consumer -> producer
interface axis_interface
  import axis_packetizer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AXIS_DATA_WIDTH
);
  localparam int unsigned KEEP_WIDTH = (DATA_WIDTH + 7) / 8;

  logic [DATA_WIDTH-1:0]      tdata;
  logic [KEEP_WIDTH-1:0]      tkeep;
  logic                       tvalid;
  logic                       tready;
  logic                       tlast;
  logic [AXIS_ID_WIDTH-1:0]   tid;
  logic [AXIS_DEST_WIDTH-1:0] tdest;
  logic [AXIS_USER_WIDTH-1:0] tuser;

  modport Sink   (input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
  modport Source (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input  tready);
endinterface

// File: rtl/axis_idle_timer.sv
// Idle timer for the packetizer: a down-counter loaded with TIMEOUT_CYCLES on
// clear, decremented on each enabled cycle, saturating at zero.
//   clk     : clock
//   reset   : synchronous active-high, reloads the counter
//   clear   : reload (takes priority over enable)
//   enable  : count this cycle
//   expired : counter has reached zero
module axis_idle_timer
  import axis_packetizer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned     CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_remaining;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_remaining <= LOAD;
    end else if (enable && (r_remaining != '0)) begin
      r_remaining <= r_remaining - 1'b1;
    end
  end

  assign expired = (r_remaining == '0);

endmodule

// File: rtl/axis_packetizer.sv
// AXI-Stream packetizer: frames an unframed beat stream by driving tlast on the
// MAX_LEN-th beat, on beats arriving with tlast, on idle timeout, or on flush.
// Every beat waits one stage in a hold register until its tlast is known.
//   clk, reset : clock, synchronous active-high reset
//   sink       : input stream (Sink modport)
//   source     : framed output stream (Source modport), tkeep all ones
//   flush      : close the held partial packet
//   pkt_count  : packets emitted, wraps at 2^16
// Build option: define AXIS_PACKETIZER_TIMEOUT_EN to build the idle timer;
// without it a partial packet waits for the next beat or a flush.
//
// state   | meaning
// EMPTY   | hold register empty
// PENDING | hold register holds a beat whose tlast is not yet known
// CLOSING | hold register holds the last beat of a packet
module axis_packetizer
  import axis_packetizer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  axis_interface.Sink                sink,
  axis_interface.Source              source,
  input  logic                       flush,
  output logic [PKT_COUNT_WIDTH-1:0] pkt_count
);
  localparam int unsigned      CNT_W    = $clog2(MAX_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_LEN - 1);

  // The hold struct has fixed field widths, so the data width must match it.
  generate
    if ((DATA_WIDTH != AXIS_DATA_WIDTH) || (MAX_LEN < 2) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
      $error("axis_packetizer: illegal DATA_WIDTH/MAX_LEN/TIMEOUT_CYCLES");
    end
  endgenerate

  packetizer_state_t          r_state;
  packetizer_state_t          w_state_next;
  hold_beat_t                 r_hold;
  hold_beat_t                 r_out;
  logic                       r_o_valid;
  logic [CNT_W-1:0]           r_beat_cnt;
  logic [PKT_COUNT_WIDTH-1:0] r_pkt_count;

  logic w_o_free;
  logic w_accept;
  logic w_new_last;
  logic w_timeout;
  logic w_timer_en;
  logic w_force_close;
  logic w_move;
  logic w_move_last;

  assign w_timer_en = (r_state == PENDING) && !w_accept;

`ifdef AXIS_PACKETIZER_TIMEOUT_EN
  axis_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_accept),
    .enable (w_timer_en),
    .expired(w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      w_state_next = w_new_last ? CLOSING : PENDING;
    end else if (w_move) begin
      w_state_next = EMPTY;
    end
  end

  // A new beat outranks timeout/flush. A flush pulse arriving while O is
  // stalled is dropped; the timer instead saturates and closes once O frees.
  always_comb begin
    w_o_free      = !r_o_valid || source.tready;
    sink.tready   = !reset && ((r_state == EMPTY) || w_o_free);
    w_accept      = sink.tvalid && sink.tready;
    w_new_last    = sink.tlast || (r_beat_cnt == LAST_IDX);
    w_force_close = (r_state == PENDING) && !w_accept && (w_timeout || flush);
    w_move        = (r_state != EMPTY) && w_o_free &&
                    (w_accept || (r_state == CLOSING) || w_force_close);
    w_move_last   = r_hold.last || w_force_close;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold      <= '0;
      r_out       <= '0;
      r_o_valid   <= 1'b0;
      r_beat_cnt  <= '0;
      r_pkt_count <= '0;
    end else begin
      if (w_accept) begin
        r_hold <= '{data: sink.tdata, id: sink.tid, dest: sink.tdest,
                    user: sink.tuser, last: w_new_last};
        r_beat_cnt <= w_new_last ? '0 : (r_beat_cnt + 1'b1);
      end else if (w_move && w_force_close) begin
        r_beat_cnt <= '0;
      end

      if (w_move) begin
        r_out <= '{data: r_hold.data, id: r_hold.id, dest: r_hold.dest,
                   user: r_hold.user, last: w_move_last};
        r_o_valid <= 1'b1;
      end else if (source.tready) begin
        r_o_valid <= 1'b0;
      end

      if (r_o_valid && source.tready && r_out.last) begin
        r_pkt_count <= r_pkt_count + 1'b1;
      end
    end
  end

  assign source.tvalid = r_o_valid;
  assign source.tdata  = r_out.data;
  assign source.tlast  = r_out.last;
  assign source.tid    = r_out.id;
  assign source.tdest  = r_out.dest;
  assign source.tuser  = r_out.user;
  assign source.tkeep  = '1;
  assign pkt_count     = r_pkt_count;

endmodule

// File: tb/tb_axis_packetizer.sv
`timescale 1ns/1ps
module tb_axis_packetizer;
  import axis_packetizer_pkg::*;

  localparam int DW = 8;
  localparam int ML = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] pkt_count;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  axis_interface #(.DATA_WIDTH(DW)) sink_if ();
  axis_interface #(.DATA_WIDTH(DW)) source_if ();

  axis_packetizer #(
    .DATA_WIDTH(DW), .MAX_LEN(ML), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .sink(sink_if), .source(source_if),
    .flush(flush), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] q_data[$];
  logic       q_last[$];
  int         q_cyc[$];
  logic [3:0] q_id[$];
  logic [3:0] q_dest[$];
  logic       q_user[$];
  logic       q_keep[$];

  always @(negedge clk) begin
    if (!reset && source_if.tvalid && source_if.tready) begin
      q_data.push_back(source_if.tdata);
      q_last.push_back(source_if.tlast);
      q_cyc.push_back(cyc);
      q_id.push_back(source_if.tid);
      q_dest.push_back(source_if.tdest);
      q_user.push_back(source_if.tuser);
      q_keep.push_back(source_if.tkeep);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    q_data.delete(); q_last.delete(); q_cyc.delete(); q_id.delete();
    q_dest.delete(); q_user.delete(); q_keep.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sink_if.tvalid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    clear_queues();
  endtask

  task automatic set_beat(input logic [7:0] d, input logic l);
    sink_if.tvalid = 1'b1;
    sink_if.tdata  = d;
    sink_if.tlast  = l;
    sink_if.tid    = d[3:0];
    sink_if.tdest  = ~d[3:0];
    sink_if.tuser  = d[0];
    sink_if.tkeep  = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input logic l, output int acc_cyc);
    int budget;
    budget = 0;
    set_beat(d, l);
    @(negedge clk);
    while (!sink_if.tready && budget < 50) begin
      budget++;
      @(negedge clk);
    end
    if (!sink_if.tready) begin
      n_checks++;
      $display("FAIL send_timeout: beat %0h never accepted", d);
    end
    tick();
    acc_cyc = cyc;
    sink_if.tvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    source_if.tready = 1'b1;
    repeat (3) tick();
    n_checks++; if (sink_if.tready !== 1'b0) $display("FAIL rst_sink_tready: got %b want 0", sink_if.tready); else n_pass++;
    n_checks++; if (source_if.tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", source_if.tvalid); else n_pass++;
    n_checks++; if (source_if.tlast !== 1'b0) $display("FAIL rst_tlast: got %b want 0", source_if.tlast); else n_pass++;
    n_checks++; if (source_if.tdata !== 8'h00) $display("FAIL rst_tdata: got %h want 00", source_if.tdata); else n_pass++;
    n_checks++; if (pkt_count !== 16'd0) $display("FAIL rst_pkt_count: got %0d want 0", pkt_count); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (sink_if.tready !== 1'b1) $display("FAIL rst_release_tready: got %b want 1", sink_if.tready); else n_pass++;
    tick();
    clear_queues();
  endtask

  task automatic test_back_to_back();
    int a;
    do_reset();
    source_if.tready = 1'b1;
    for (int i = 0; i < 8; i++) send(8'(i), 1'b0, a);
    repeat (4) tick();
    n_checks++; if (q_data.size() !== 8) $display("FAIL b2b_count: got %0d want 8", q_data.size()); else n_pass++;
    if (q_data.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        n_checks++; if (q_data[i] !== 8'(i)) $display("FAIL b2b_data[%0d]: got %h want %h", i, q_data[i], 8'(i)); else n_pass++;
        n_checks++; if (q_last[i] !== ((i == 3) || (i == 7))) $display("FAIL b2b_last[%0d]: got %b want %b", i, q_last[i], (i == 3) || (i == 7)); else n_pass++;
        n_checks++;
        if (q_id[i] !== 4'(i) || q_dest[i] !== ~4'(i) || q_user[i] !== (i % 2 == 1) || q_keep[i] !== 1'b1)
          $display("FAIL b2b_side[%0d]: got id=%h dest=%h user=%b keep=%b want id=%h dest=%h user=%b keep=1",
                   i, q_id[i], q_dest[i], q_user[i], q_keep[i], 4'(i), ~4'(i), (i % 2 == 1));
        else n_pass++;
      end
      n_checks++; if (q_cyc[7] - q_cyc[0] !== 7) $display("FAIL b2b_throughput: got span %0d want 7", q_cyc[7] - q_cyc[0]); else n_pass++;
    end
    n_checks++; if (pkt_count !== 16'd2) $display("FAIL b2b_pkt_count: got %0d want 2", pkt_count); else n_pass++;
  endtask

  task automatic test_timeout();
    int a;
    int acc2;
    do_reset();
    source_if.tready = 1'b1;
    send(8'd0, 1'b0, a);
    send(8'd1, 1'b0, a);
    send(8'd2, 1'b0, acc2);
    repeat (TO + 6) tick();
`ifdef AXIS_PACKETIZER_TIMEOUT_EN
    n_checks++; if (q_data.size() !== 3) $display("FAIL to_count: got %0d want 3", q_data.size()); else n_pass++;
    if (q_data.size() == 3) begin
      n_checks++; if (q_data[2] !== 8'd2 || q_last[2] !== 1'b1) $display("FAIL to_beat2: got %h/%b want 02/1", q_data[2], q_last[2]); else n_pass++;
      n_checks++; if (q_last[1] !== 1'b0) $display("FAIL to_beat1_last: got %b want 0", q_last[1]); else n_pass++;
      n_checks++; if (q_cyc[2] !== acc2 + TO + 1) $display("FAIL to_latency: got cycle %0d want %0d", q_cyc[2], acc2 + TO + 1); else n_pass++;
    end
    n_checks++; if (pkt_count !== 16'd1) $display("FAIL to_pkt_count: got %0d want 1", pkt_count); else n_pass++;
`else
    n_checks++; if (q_data.size() !== 2) $display("FAIL noto_count: got %0d want 2", q_data.size()); else n_pass++;
    n_checks++; if (pkt_count !== 16'd0) $display("FAIL noto_pkt_count: got %0d want 0", pkt_count); else n_pass++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (2) tick();
    n_checks++; if (q_data.size() !== 3) $display("FAIL noto_flush_count: got %0d want 3", q_data.size()); else n_pass++;
    if (q_data.size() == 3) begin
      n_checks++; if (q_data[2] !== 8'd2 || q_last[2] !== 1'b1) $display("FAIL noto_beat2: got %h/%b want 02/1", q_data[2], q_last[2]); else n_pass++;
    end
`endif
  endtask

  task automatic test_input_tlast();
    int a;
    do_reset();
    source_if.tready = 1'b1;
    for (int i = 0; i < 6; i++) send(8'(i), (i == 1), a);
    repeat (3) tick();
    n_checks++; if (q_data.size() !== 6) $display("FAIL tl_count: got %0d want 6", q_data.size()); else n_pass++;
    if (q_data.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (q_data[i] !== 8'(i) || q_last[i] !== ((i == 1) || (i == 5)))
          $display("FAIL tl_beat[%0d]: got %h/%b want %h/%b", i, q_data[i], q_last[i], 8'(i), (i == 1) || (i == 5));
        else n_pass++;
      end
    end
    n_checks++; if (pkt_count !== 16'd2) $display("FAIL tl_pkt_count: got %0d want 2", pkt_count); else n_pass++;
  endtask

  task automatic test_backpressure();
    int  idx;
    int  budget;
    logic acc;
    do_reset();
    source_if.tready = 1'b0;
    idx = 0;
    set_beat(8'd0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      acc = sink_if.tready;
      tick();
      if (acc) begin idx++; set_beat(8'(idx), 1'b0); end
    end
    n_checks++; if (idx !== 2) $display("FAIL bp_accepts: got %0d want 2", idx); else n_pass++;
    n_checks++; if (sink_if.tready !== 1'b0) $display("FAIL bp_sink_tready: got %b want 0", sink_if.tready); else n_pass++;
    n_checks++; if (source_if.tvalid !== 1'b1 || source_if.tdata !== 8'd0) $display("FAIL bp_hold_out: got %b/%h want 1/00", source_if.tvalid, source_if.tdata); else n_pass++;
    source_if.tready = 1'b1;
    budget = 0;
    while (idx < 6 && budget < 30) begin
      budget++;
      @(negedge clk);
      acc = sink_if.tready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 6) set_beat(8'(idx), 1'b0); else sink_if.tvalid = 1'b0;
      end
    end
    sink_if.tvalid = 1'b0;
    n_checks++; if (idx !== 6) $display("FAIL bp_release_accepts: got %0d want 6", idx); else n_pass++;
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (3) tick();
    n_checks++; if (q_data.size() !== 6) $display("FAIL bp_count: got %0d want 6", q_data.size()); else n_pass++;
    if (q_data.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (q_data[i] !== 8'(i) || q_last[i] !== ((i == 3) || (i == 5)))
          $display("FAIL bp_beat[%0d]: got %h/%b want %h/%b", i, q_data[i], q_last[i], 8'(i), (i == 3) || (i == 5));
        else n_pass++;
      end
    end
    n_checks++; if (pkt_count !== 16'd2) $display("FAIL bp_pkt_count: got %0d want 2", pkt_count); else n_pass++;
  endtask

  task automatic test_flush();
    int a;
    int fe;
    do_reset();
    source_if.tready = 1'b1;
    send(8'd5, 1'b0, a);
    repeat (2) tick();
    n_checks++; if (q_data.size() !== 0) $display("FAIL fl_early: got %0d beats want 0", q_data.size()); else n_pass++;
    flush = 1'b1;
    tick();
    fe = cyc;
    flush = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (q_data.size() !== 1) $display("FAIL fl_count: got %0d want 1", q_data.size()); else n_pass++;
    if (q_data.size() == 1) begin
      n_checks++; if (q_data[0] !== 8'd5 || q_last[0] !== 1'b1) $display("FAIL fl_beat: got %h/%b want 05/1", q_data[0], q_last[0]); else n_pass++;
      n_checks++; if (q_cyc[0] !== fe) $display("FAIL fl_latency: got cycle %0d want %0d", q_cyc[0], fe); else n_pass++;
    end
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (4) tick();
    n_checks++; if (q_data.size() !== 1) $display("FAIL fl_empty_flush: got %0d beats want 1", q_data.size()); else n_pass++;
    n_checks++; if (pkt_count !== 16'd1) $display("FAIL fl_pkt_count: got %0d want 1", pkt_count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int a;
    do_reset();
    source_if.tready = 1'b0;
    send(8'h10, 1'b0, a);
    send(8'h11, 1'b0, a);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    source_if.tready = 1'b1;
    repeat (5) tick();
    n_checks++; if (q_data.size() !== 0) $display("FAIL rm_discard: got %0d beats want 0", q_data.size()); else n_pass++;
    n_checks++; if (pkt_count !== 16'd0) $display("FAIL rm_pkt_count0: got %0d want 0", pkt_count); else n_pass++;
    for (int i = 0; i < 4; i++) send(8'(32 + i), 1'b0, a);
    repeat (4) tick();
    n_checks++; if (q_data.size() !== 4) $display("FAIL rm_count: got %0d want 4", q_data.size()); else n_pass++;
    if (q_data.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (q_data[i] !== 8'(32 + i) || q_last[i] !== (i == 3))
          $display("FAIL rm_beat[%0d]: got %h/%b want %h/%b", i, q_data[i], q_last[i], 8'(32 + i), (i == 3));
        else n_pass++;
      end
    end
    n_checks++; if (pkt_count !== 16'd1) $display("FAIL rm_pkt_count1: got %0d want 1", pkt_count); else n_pass++;
  endtask

  initial begin
    sink_if.tvalid = 1'b0;
    sink_if.tdata  = '0;
    sink_if.tlast  = 1'b0;
    sink_if.tid    = '0;
    sink_if.tdest  = '0;
    sink_if.tuser  = '0;
    sink_if.tkeep  = '1;
    source_if.tready = 1'b1;

    test_reset();
    test_back_to_back();
    test_timeout();
    test_input_tlast();
    test_backpressure();
    test_flush();
    test_reset_mid();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
